// File: rtl/dac_stream_monitor.sv
// DAC output capture and continuity monitor: per-channel sample hold, format conversion,
// step-size checking with sticky flags, saturating error counters and max-step tracking.
module dac_stream_monitor #(
   parameter int unsigned DW      = 14,
   parameter int unsigned CHN     = 2,
   parameter int unsigned MODE    = 0,
   parameter int unsigned FMT_INV = 1,
   parameter int unsigned CW      = 16,
   parameter int unsigned SW      = 3
) (
   input  logic                  dac_clk_i,
   input  logic                  dac_rst_i,
   input  logic [CHN*DW-1:0]     dac_dat_i,
   input  logic                  dac_wrt_i,
   input  logic [SW-1:0]         dac_sel_i,
   input  logic [DW-1:0]         max_step_i,
   input  logic                  clr_i,
   output logic [CHN*DW-1:0]     dac_o,
   output logic [CHN-1:0]        dac_vld_o,
   output logic [CHN-1:0]        step_err_o,
   output logic [CHN*CW-1:0]     err_cnt_o,
   output logic [CHN*(DW+1)-1:0] max_obs_o
);

   typedef enum logic {StUnarmed, StArmed} state_e;

   // Which input bits are consumed depends on MODE and CHN.
   logic w_unused;
   assign w_unused = ^{dac_dat_i, dac_sel_i};

   for (genvar c = 0; c < CHN; c++) begin : g_ch
      localparam int unsigned Lane = (MODE == 0) ? 0 : c;

      state_e        r_state, w_state_d;
      logic [DW-1:0] w_raw, w_conv, r_dat;
      logic          w_cap, w_check, w_big, w_new_max;
      logic [DW:0]   w_diff, w_step;
      logic          r_vld, r_err;
      logic [CW-1:0] r_cnt;
      logic [DW:0]   r_max;

      assign w_raw = dac_dat_i[Lane*DW +: DW];

      if (FMT_INV != 0) begin : g_inv
         assign w_conv = {w_raw[DW-1], ~w_raw[DW-2:0]};
      end else begin : g_pass
         assign w_conv = w_raw;
      end

      if (MODE == 0) begin : g_il
         assign w_cap = !dac_wrt_i && (dac_sel_i == SW'(c));
      end else begin : g_par
         assign w_cap = !dac_wrt_i;
      end

      always_comb begin
         w_state_d = r_state;
         unique case (r_state)
            StUnarmed: if (w_cap) w_state_d = StArmed;
            StArmed:   w_state_d = StArmed;
            default:   w_state_d = StUnarmed;
         endcase
      end

      // Sign-extend by one bit so the difference of two DW-bit values cannot overflow.
      always_comb begin
         w_diff    = {w_conv[DW-1], w_conv} - {r_dat[DW-1], r_dat};
         w_step    = w_diff[DW] ? (~w_diff + (DW+1)'(1)) : w_diff;
         w_check   = w_cap && (r_state == StArmed);
         w_big     = w_step > {1'b0, max_step_i};
         w_new_max = w_step > r_max;
      end

      always_ff @(posedge dac_clk_i) begin
         if (dac_rst_i) begin
            r_state <= StUnarmed;
            r_dat   <= '0;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_max   <= '0;
         end else begin
            r_state <= w_state_d;
            r_vld   <= w_cap;
            if (w_cap) r_dat <= w_conv;
            // Clear takes priority over a coincident step error.
            if (clr_i) begin
               r_err <= 1'b0;
               r_cnt <= '0;
               r_max <= '0;
            end else if (w_check) begin
               if (w_big) begin
                  r_err <= 1'b1;
                  if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
               end
               if (w_new_max) r_max <= w_step;
            end
         end
      end

      assign dac_o[c*DW +: DW]          = r_dat;
      assign dac_vld_o[c]               = r_vld;
      assign step_err_o[c]              = r_err;
      assign err_cnt_o[c*CW +: CW]      = r_cnt;
      assign max_obs_o[c*(DW+1) +: DW+1] = r_max;
   end

endmodule
